// File: rtl/alu_dispatch.sv
// alu_dispatch: queues ALU requests in a small FIFO, issues the head to an
// external combinational ALU and registers the ALU response into a result
// slot. The slot uses a valid/ready handshake.
//
// Optional build macro: ALU_DISPATCH_BYPASS_EN
//   When it is defined, a request that arrives while the FIFO is empty and the
//   result slot is free goes straight to the ALU in the same cycle. This gives
//   a latency of one cycle instead of two.
//
// Ports:
//   clk_i, rst_i            clock (rising edge), async active-high reset
//   flush_i                 synchronous discard of queued and held work
//   req_valid_i/req_ready_o request handshake
//   req_op_i/a_i/b_i/id_i   request payload
//   alu_operator_o/operand_a_o/operand_b_o   drive the combinational ALU
//   alu_result_i/alu_branch_res_i            ALU response, same cycle
//   res_valid_o/res_ready_i result handshake
//   res_data_o/branch_o/id_o result payload
//   count_o                 FIFO occupancy
module alu_dispatch #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned OP_W  = 8,
    parameter int unsigned ID_W  = 3
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [OP_W-1:0]          req_op_i,
    input  logic [XLEN-1:0]          req_a_i,
    input  logic [XLEN-1:0]          req_b_i,
    input  logic [ID_W-1:0]          req_id_i,
    output logic [OP_W-1:0]          alu_operator_o,
    output logic [XLEN-1:0]          alu_operand_a_o,
    output logic [XLEN-1:0]          alu_operand_b_o,
    input  logic [XLEN-1:0]          alu_result_i,
    input  logic                     alu_branch_res_i,
    output logic                     res_valid_o,
    input  logic                     res_ready_i,
    output logic [XLEN-1:0]          res_data_o,
    output logic                     res_branch_o,
    output logic [ID_W-1:0]          res_id_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    // FIFO storage; the payload needs no reset because count qualifies it
    logic [OP_W-1:0] op_mem [DEPTH];
    logic [XLEN-1:0] a_mem  [DEPTH];
    logic [XLEN-1:0] b_mem  [DEPTH];
    logic [ID_W-1:0] id_mem [DEPTH];

    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          ready_en_q;

    logic has_head_c;
    logic slot_free_c;
    logic req_ready_c;
    logic push_c;
    logic push_fifo_c;
    logic pop_c;
    logic bypass_c;
    logic load_c;
    logic [ID_W-1:0] issue_id_c;

    assign has_head_c  = (count_q != CW'(0));
    assign slot_free_c = !res_valid_o || res_ready_i;
    // ready_en_q keeps the port low through reset and releases it on the first edge after reset
    assign req_ready_c = ready_en_q && (count_q < CW'(DEPTH)) && !flush_i;
    assign req_ready_o = req_ready_c;
    assign push_c      = req_valid_i && req_ready_c;
    assign pop_c       = has_head_c && slot_free_c && !flush_i;

`ifdef ALU_DISPATCH_BYPASS_EN
    // flush_i is already excluded because push_c requires req_ready_c
    assign bypass_c = push_c && !has_head_c && slot_free_c;
`else
    assign bypass_c = 1'b0;
`endif

    assign push_fifo_c = push_c && !bypass_c;
    assign load_c      = pop_c || bypass_c;
    assign count_o     = count_q;

    // ALU drive: FIFO head when occupied, bypassed request otherwise, else zero
    always_comb begin
        alu_operator_o  = '0;
        alu_operand_a_o = '0;
        alu_operand_b_o = '0;
        issue_id_c      = '0;
        if (has_head_c) begin
            alu_operator_o  = op_mem[rd_ptr_q];
            alu_operand_a_o = a_mem[rd_ptr_q];
            alu_operand_b_o = b_mem[rd_ptr_q];
            issue_id_c      = id_mem[rd_ptr_q];
        end else if (bypass_c) begin
            alu_operator_o  = req_op_i;
            alu_operand_a_o = req_a_i;
            alu_operand_b_o = req_b_i;
            issue_id_c      = req_id_i;
        end
    end

    // FIFO payload write
    always_ff @(posedge clk_i) begin
        if (push_fifo_c && !flush_i) begin
            op_mem[wr_ptr_q] <= req_op_i;
            a_mem[wr_ptr_q]  <= req_a_i;
            b_mem[wr_ptr_q]  <= req_b_i;
            id_mem[wr_ptr_q] <= req_id_i;
        end
    end

    // Pointers and occupancy; flush overrides push and pop
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ready_en_q <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
            if (flush_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push_fifo_c) begin
                    wr_ptr_q <= wr_ptr_q + AW'(1);
                end
                if (pop_c) begin
                    rd_ptr_q <= rd_ptr_q + AW'(1);
                end
                if (push_fifo_c && !pop_c) begin
                    count_q <= count_q + CW'(1);
                end else if (!push_fifo_c && pop_c) begin
                    count_q <= count_q - CW'(1);
                end
            end
        end
    end

    // Result slot: load on issue, drain on ready, hold while stalled
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            res_valid_o  <= 1'b0;
            res_data_o   <= '0;
            res_branch_o <= 1'b0;
            res_id_o     <= '0;
        end else if (flush_i) begin
            res_valid_o <= 1'b0;
        end else if (load_c) begin
            res_valid_o  <= 1'b1;
            res_data_o   <= alu_result_i;
            res_branch_o <= alu_branch_res_i;
            res_id_o     <= issue_id_c;
        end else if (res_ready_i) begin
            res_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_dispatch.sv
// Directed bench for alu_dispatch with default parameters. It models the
// external ALU as follows:
//   op 0 = ADD
//   op 1 = SUB
//   op 2 = SLL
//   the branch response is high when a == b.
module tb_alu_dispatch;

`ifdef ALU_DISPATCH_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [7:0]  req_op = '0;
    logic [63:0] req_a = '0;
    logic [63:0] req_b = '0;
    logic [2:0]  req_id = '0;
    logic [7:0]  alu_op;
    logic [63:0] alu_a;
    logic [63:0] alu_b;
    logic [63:0] alu_res;
    logic        alu_br;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [63:0] res_data;
    logic        res_branch;
    logic [2:0]  res_id;
    logic [2:0]  count;

    int vectors = 0;
    int miscompares = 0;

    alu_dispatch dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .flush_i          (flush),
        .req_valid_i      (req_valid),
        .req_ready_o      (req_ready),
        .req_op_i         (req_op),
        .req_a_i          (req_a),
        .req_b_i          (req_b),
        .req_id_i         (req_id),
        .alu_operator_o   (alu_op),
        .alu_operand_a_o  (alu_a),
        .alu_operand_b_o  (alu_b),
        .alu_result_i     (alu_res),
        .alu_branch_res_i (alu_br),
        .res_valid_o      (res_valid),
        .res_ready_i      (res_ready),
        .res_data_o       (res_data),
        .res_branch_o     (res_branch),
        .res_id_o         (res_id),
        .count_o          (count)
    );

    always #5 clk = ~clk;

    always_comb begin
        case (alu_op)
            8'd0:    alu_res = alu_a + alu_b;
            8'd1:    alu_res = alu_a - alu_b;
            8'd2:    alu_res = alu_a << alu_b[5:0];
            default: alu_res = '0;
        endcase
        alu_br = (alu_a == alu_b);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [2:0] id);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_id    = id;
    endtask

    task automatic idle();
        req_valid = 1'b0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        req_id    = '0;
    endtask

    task automatic single(input string tag, input logic [7:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic [2:0] id,
                          input logic [63:0] exp_data, input logic exp_br);
        res_ready = 1'b1;
        send(op, a, b, id);
        tick();
        idle();
        if (LAT == 2) begin
            chk({tag, "_early_valid"}, 64'(res_valid), 64'd0);
            chk({tag, "_count"}, 64'(count), 64'd1);
            chk({tag, "_alu_a"}, alu_a, a);
            tick();
        end
        chk({tag, "_valid"}, 64'(res_valid), 64'd1);
        chk({tag, "_data"}, res_data, exp_data);
        chk({tag, "_branch"}, 64'(res_branch), 64'(exp_br));
        chk({tag, "_id"}, 64'(res_id), 64'(id));
        tick();
        chk({tag, "_drain"}, 64'(res_valid), 64'd0);
    endtask

    initial begin
        #1 rst = 1'b1;
        #1;
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_valid", 64'(res_valid), 64'd0);
        chk("rst_data", res_data, 64'd0);
        chk("rst_alu_op", 64'(alu_op), 64'd0);
        tick();
        tick();
        chk("rst_ready_hold", 64'(req_ready), 64'd0);
        rst = 1'b0;
        tick();
        chk("ready_after_rst", 64'(req_ready), 64'd1);

        // single requests
        single("add", 8'd0, 64'd1, 64'd2, 3'd5, 64'd3, 1'b0);
        single("add_eq", 8'd0, 64'd9, 64'd9, 3'd3, 64'd18, 1'b1);

        // stall stability
        res_ready = 1'b0;
        send(8'd1, 64'd1, 64'd2, 3'd2);
        tick();
        idle();
        for (int i = 1; i < LAT; i++) tick();
        for (int i = 0; i < 3; i++) begin
            chk("stall_valid", 64'(res_valid), 64'd1);
            chk("stall_data", res_data, 64'hFFFF_FFFF_FFFF_FFFF);
            chk("stall_id", 64'(res_id), 64'd2);
            tick();
        end
        res_ready = 1'b1;
        tick();
        chk("stall_drain", 64'(res_valid), 64'd0);

        // backpressure fill
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send(8'd0, 64'(i), 64'd10, 3'(i));
            chk("bp_ready_push", 64'(req_ready), 64'd1);
            tick();
        end
        idle();
        chk("bp_count", 64'(count), 64'd4);
        chk("bp_ready_full", 64'(req_ready), 64'd0);
        chk("bp_valid", 64'(res_valid), 64'd1);
        chk("bp_head_id", 64'(res_id), 64'd0);
        res_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_order_valid", 64'(res_valid), 64'd1);
            chk("bp_order_id", 64'(res_id), 64'(i));
            chk("bp_order_data", res_data, 64'(i + 10));
            tick();
        end
        chk("bp_empty_valid", 64'(res_valid), 64'd0);
        chk("bp_empty_count", 64'(count), 64'd0);

        // streaming shifts
        res_ready = 1'b1;
        for (int c = 0; c <= 15 + LAT - 1; c++) begin
            if (c < 16) send(8'd2, 64'd1, 64'(c), 3'(c));
            else idle();
            tick();
            if (c - (LAT - 1) >= 0 && c - (LAT - 1) < 16) begin
                chk("stream_valid", 64'(res_valid), 64'd1);
                chk("stream_data", res_data, 64'd1 << (c - (LAT - 1)));
            end
        end
        idle();
        tick();
        chk("stream_end", 64'(res_valid), 64'd0);

        // flush with 3 queued and 1 held
        res_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            send(8'd0, 64'(i), 64'd0, 3'(i));
            tick();
        end
        chk("fl_pre_count", 64'(count), 64'd3);
        chk("fl_pre_valid", 64'(res_valid), 64'd1);
        flush = 1'b1;
        send(8'd0, 64'd7, 64'd7, 3'd7);
        #1;
        chk("fl_ready_low", 64'(req_ready), 64'd0);
        tick();
        flush = 1'b0;
        idle();
        chk("fl_count", 64'(count), 64'd0);
        chk("fl_valid", 64'(res_valid), 64'd0);
        res_ready = 1'b1;
        tick();
        tick();
        chk("fl_no_accept", 64'(res_valid), 64'd0);

        // reset mid-stream
        res_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(8'd0, 64'(i), 64'd1, 3'(i));
            tick();
        end
        idle();
        chk("mr_pre_count", 64'(count), 64'd2);
        chk("mr_pre_valid", 64'(res_valid), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("mr_valid", 64'(res_valid), 64'd0);
        chk("mr_count", 64'(count), 64'd0);
        chk("mr_data", res_data, 64'd0);
        chk("mr_id", 64'(res_id), 64'd0);
        chk("mr_ready", 64'(req_ready), 64'd0);
        chk("mr_alu_a", alu_a, 64'd0);
        tick();
        rst = 1'b0;
        res_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("mr_no_result", 64'(res_valid), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
